mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the 4:1 mux and drives its 2-bit select.
- Four requesters compete for the shared mux output path.
- The arbiter registers a winner, holds the grant while the owner keeps requesting, and rotates fairly.
- A grant is preempted after MAX_HOLD cycles when other requesters are waiting.

---
 rtl/mux_rr_arbiter_pkg.sv | 7 +
 rtl/mux_rr_arbiter_rr_pick.sv | 24 ++
 rtl/mux_rr_arbiter.sv | 62 ++++++
 tb/tb_mux_rr_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared sizes and FSM state encoding for the mux round-robin arbiter
// Contents: N_REQ requester count, SEL_W select width, state_t (ST_IDLE / ST_GRANT)
package mux_rr_arbiter_pkg;
   localparam int N_REQ = 4;
   localparam int SEL_W = 2;
   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first unmasked request at or after ptr
// Ports: req (requests), mask (bits excluded from the scan), ptr (scan start),
//        found (some unmasked request exists), idx (winning index)
module rr_pick
   import mux_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] mask,
   input  logic [SEL_W-1:0] ptr,
   output logic             found,
   output logic [SEL_W-1:0] idx
);
   logic [N_REQ-1:0] m;
   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;
   always_comb begin
      m     = req & ~mask;
      // rot[k] is the request at (ptr + k) mod 4, so the scan becomes a fixed priority encode
      rot   = N_REQ'({m, m} >> ptr);
      off   = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
      found = |m;
      idx   = ptr + off;
   end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving the 2-bit select of a 4:1 mux
// Ports: clk, rst (sync active-high), req[3:0] (one per mux input),
//        sel[1:0] (registered mux select), gnt[3:0] (registered one-hot grant),
//        gnt_valid (high while a grant is held)
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [SEL_W-1:0] sel,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid
);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   state_t            state, state_n;
   logic [SEL_W-1:0]  ptr, ptr_n, sel_n, idx;
   logic [N_REQ-1:0]  gnt_n, mask;
   logic [HOLD_W-1:0] hold_cnt, hold_n;
   logic              gnt_valid_n, found, own_req, take;
   rr_pick u_pick (
      .req   (req),
      .mask  (mask),
      .ptr   (ptr),
      .found (found),
      .idx   (idx)
   );
   always_comb begin
      // the current owner is excluded from the scan, so found means "someone else is waiting"
      mask        = (state == ST_GRANT) ? (N_REQ'(1) << sel) : '0;
      own_req     = req[sel];
      take        = found && (state == ST_IDLE || !own_req || hold_cnt == HOLD_LAST);
      state_n     = (take || (state == ST_GRANT && own_req)) ? ST_GRANT : ST_IDLE;
      sel_n       = take ? idx : sel;
      gnt_n       = take ? (N_REQ'(1) << idx) : (state_n == ST_GRANT) ? gnt : '0;
      gnt_valid_n = (state_n == ST_GRANT);
      ptr_n       = take ? idx + 2'd1 : ptr;
      hold_n      = take ? '0 : (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         sel       <= '0;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         ptr       <= '0;
         hold_cnt  <= '0;
      end else begin
         state     <= state_n;
         sel       <= sel_n;
         gnt       <= gnt_n;
         gnt_valid <= gnt_valid_n;
         ptr       <= ptr_n;
         hold_cnt  <= hold_n;
      end
   end
   a_gnt_consistent: assert property (@(posedge clk) disable iff (rst)
      $onehot0(gnt) && (gnt_valid == |gnt) && (!gnt_valid || gnt == (N_REQ'(1) << sel)));
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: self-checking bench for mux_rr_arbiter against a behavioural model
module tb_mux_rr_arbiter;
   localparam int MAX_HOLD = 8;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       gnt_valid;
   int checks = 0;
   int errors = 0;
   int m_owner = -1;
   int m_last  = 3;
   int m_cnt   = 0;
   int m_sel   = 0;

   mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .sel       (sel),
      .gnt       (gnt),
      .gnt_valid (gnt_valid)
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [3:0] r, input int excl);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (m_last + 1 + k) % 4;
         if (r[i] && i != excl) return i;
      end
      return -1;
   endfunction

   function automatic void grant_to(input int c);
      m_owner = c;
      m_last  = c;
      m_cnt   = 1;
      m_sel   = c;
   endfunction

   function automatic void model_step(input logic [3:0] r, input logic rs);
      int c;
      if (rs) begin
         m_owner = -1;
         m_last  = 3;
         m_cnt   = 0;
         m_sel   = 0;
      end else begin
         c = pick(r, m_owner);
         if (m_owner < 0) begin
            if (c >= 0) grant_to(c);
         end else if (!r[m_owner]) begin
            if (c >= 0) grant_to(c);
            else m_owner = -1;
         end else if (m_cnt >= MAX_HOLD && c >= 0) begin
            grant_to(c);
         end else begin
            m_cnt++;
         end
      end
   endfunction

   function automatic logic [6:0] exp_vec();
      logic [3:0] g;
      g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      return {2'(m_sel), g, m_owner >= 0};
   endfunction

   task automatic step(input logic [3:0] r, input logic rs);
      req = r;
      rst = rs;
      @(posedge clk);
      model_step(r, rs);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(4'b1111, 1'b1);
         checks++;
         if ({sel, gnt, gnt_valid} !== 7'b00_0000_0) begin
            errors++;
            $display("FAIL reset cyc %0d got %b exp %b", i, {sel, gnt, gnt_valid}, 7'b00_0000_0);
         end
      end
      step(4'b0000, 1'b0);
      checks++;
      if ({sel, gnt, gnt_valid} !== 7'b00_0000_0) begin
         errors++;
         $display("FAIL reset_idle got %b exp %b", {sel, gnt, gnt_valid}, 7'b00_0000_0);
      end
      step(4'b0001, 1'b0);
      checks++;
      if ({sel, gnt, gnt_valid} !== 7'b00_0001_1) begin
         errors++;
         $display("FAIL first_grant got %b exp %b", {sel, gnt, gnt_valid}, 7'b00_0001_1);
      end
   endtask

   task automatic test_rotation();
      step(4'b0000, 1'b1);
      for (int i = 0; i < 4 * MAX_HOLD + 2; i++) begin
         step(4'b1111, 1'b0);
         checks++;
         if ({sel, gnt, gnt_valid} !== exp_vec() || gnt !== (4'b0001 << ((i / MAX_HOLD) % 4))) begin
            errors++;
            $display("FAIL rotation cyc %0d got %b exp %b", i, {sel, gnt, gnt_valid}, exp_vec());
         end
      end
   endtask

   task automatic test_release();
      step(4'b0000, 1'b1);
      for (int i = 0; i < 3; i++) step(4'b0101, 1'b0);
      checks++;
      if ({sel, gnt, gnt_valid} !== 7'b00_0001_1) begin
         errors++;
         $display("FAIL release_owner0 got %b exp %b", {sel, gnt, gnt_valid}, 7'b00_0001_1);
      end
      step(4'b0100, 1'b0);
      checks++;
      if ({sel, gnt, gnt_valid} !== 7'b10_0100_1) begin
         errors++;
         $display("FAIL release_handover got %b exp %b", {sel, gnt, gnt_valid}, 7'b10_0100_1);
      end
      step(4'b0000, 1'b0);
      checks++;
      if ({sel, gnt, gnt_valid} !== 7'b10_0000_0) begin
         errors++;
         $display("FAIL release_idle got %b exp %b", {sel, gnt, gnt_valid}, 7'b10_0000_0);
      end
   endtask

   task automatic test_saturation();
      step(4'b0000, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(4'b1000, 1'b0);
         checks++;
         if ({sel, gnt, gnt_valid} !== 7'b11_1000_1) begin
            errors++;
            $display("FAIL saturation cyc %0d got %b exp %b", i, {sel, gnt, gnt_valid}, 7'b11_1000_1);
         end
      end
   endtask

   task automatic test_wrap();
      step(4'b0000, 1'b0);
      step(4'b0011, 1'b0);
      checks++;
      if ({sel, gnt, gnt_valid} !== 7'b00_0001_1) begin
         errors++;
         $display("FAIL wrap_winner got %b exp %b", {sel, gnt, gnt_valid}, 7'b00_0001_1);
      end
      for (int i = 1; i <= MAX_HOLD; i++) begin
         step(4'b0011, 1'b0);
         checks++;
         if ({sel, gnt, gnt_valid} !== ((i < MAX_HOLD) ? 7'b00_0001_1 : 7'b01_0010_1)) begin
            errors++;
            $display("FAIL wrap_preempt cyc %0d got %b exp %b", i, {sel, gnt, gnt_valid}, exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      step(4'b0000, 1'b1);
      for (int i = 0; i < 5; i++) step(4'b0010, 1'b0);
      step(4'b0010, 1'b1);
      checks++;
      if ({sel, gnt, gnt_valid} !== 7'b00_0000_0) begin
         errors++;
         $display("FAIL reset_mid got %b exp %b", {sel, gnt, gnt_valid}, 7'b00_0000_0);
      end
      step(4'b0010, 1'b0);
      checks++;
      if ({sel, gnt, gnt_valid} !== 7'b01_0010_1) begin
         errors++;
         $display("FAIL reset_mid_regrant got %b exp %b", {sel, gnt, gnt_valid}, 7'b01_0010_1);
      end
      step(4'b0100, 1'b0);
      step(4'b0100, 1'b1);
      step(4'b1010, 1'b0);
      checks++;
      if ({sel, gnt, gnt_valid} !== 7'b01_0010_1) begin
         errors++;
         $display("FAIL reset_ptr_restart got %b exp %b", {sel, gnt, gnt_valid}, 7'b01_0010_1);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      int left;
      step(4'b0000, 1'b1);
      r = 4'b0000;
      left = 0;
      for (int i = 0; i < 500; i++) begin
         if (left == 0) begin
            r = 4'($urandom_range(0, 15));
            left = $urandom_range(1, 12);
         end
         left--;
         step(r, $urandom_range(0, 49) == 0);
         checks++;
         if ({sel, gnt, gnt_valid} !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc %0d req %b got %b exp %b", i, r, {sel, gnt, gnt_valid}, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_release();
      test_saturation();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
